// File: rtl/usr_shift_ctrl.sv
// usr_shift_ctrl: sequencer in front of a universal shift register.
// Accepts parallel words over valid/ready, parallel-loads each word into the
// shift register, then steps it out one bit per clock (LSB or MSB first,
// chosen per word) as a framed serial stream with valid/last flags.
module usr_shift_ctrl #(
  parameter int   WIDTH = 4,
  parameter int   GAP   = 1,
  parameter logic FILL  = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_dir,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             usr_s1,
  output logic             usr_s0,
  output logic [WIDTH-1:0] usr_in,
  output logic             usr_msb_in,
  output logic             usr_lsb_in,
  input  logic             usr_msb_out,
  input  logic             usr_lsb_out,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  // Shift register mode selects {s1,s0}
  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_RIGHT = 2'b01;
  localparam logic [1:0] M_LEFT  = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP > 0) ? GAP - 1 : 0);

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [GW-1:0]    r_gcnt;
  logic [WIDTH-1:0] r_hold;
  logic             r_dir;

  logic             w_accept;
  logic             w_last_bit;
  logic [1:0]       w_sel;

  // Ready only in IDLE and never while reset is asserted, so a word offered
  // during reset is not taken.
  assign din_ready  = (r_state == S_IDLE) && !reset;
  assign w_accept   = din_valid && din_ready;
  assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);

  // State, bit/gap counters and the per-word hold/direction registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_gcnt  <= '0;
      r_hold  <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_hold  <= din;
            r_dir   <= din_dir;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_SHIFT;
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_cnt   <= '0;
            r_gcnt  <= '0;
            r_state <= (GAP == 0) ? S_IDLE : S_GAP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_GAP: begin
          if (r_gcnt == GAP_LAST) begin
            r_gcnt  <= '0;
            r_state <= S_IDLE;
          end else begin
            r_gcnt <= r_gcnt + GW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of mode selects and stream framing from registered state.
  always_comb begin
    w_sel     = M_HOLD;
    ser_valid = 1'b0;
    ser_last  = 1'b0;
    case (r_state)
      S_LOAD: w_sel = M_LOAD;
      S_SHIFT: begin
        ser_valid = 1'b1;
        ser_last  = w_last_bit;
        // The final bit is already at the output end; no further shift needed.
        if (!w_last_bit) w_sel = r_dir ? M_LEFT : M_RIGHT;
      end
      default: w_sel = M_HOLD;
    endcase
  end

  assign usr_s1     = w_sel[1];
  assign usr_s0     = w_sel[0];
  assign usr_in     = r_hold;
  assign usr_msb_in = FILL;
  assign usr_lsb_in = FILL;
  assign busy       = (r_state != S_IDLE);
  // Right shifts present bits at the LSB end, left shifts at the MSB end.
  assign ser_out    = ser_valid && (r_dir ? usr_msb_out : usr_lsb_out);

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Bench for usr_shift_ctrl: two instances (GAP=1 and GAP=0), each closing the
// loop through a behavioural 4-bit universal shift register.
module tb_usr_shift_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] din = 4'h0;
  logic       dir = 1'b0;
  logic       vld_a = 1'b0;
  logic       vld_b = 1'b0;

  always #5 clk = ~clk;

  // Instance A (GAP=1) signals
  logic       rdy_a, s1_a, s0_a, mi_a, li_a, mo_a, lo_a, so_a, sv_a, sl_a, busy_a;
  logic [3:0] ui_a;
  logic [3:0] q_a = 4'h0;
  // Instance B (GAP=0) signals
  logic       rdy_b, s1_b, s0_b, mi_b, li_b, mo_b, lo_b, so_b, sv_b, sl_b, busy_b;
  logic [3:0] ui_b;
  logic [3:0] q_b = 4'h0;

  usr_shift_ctrl #(.WIDTH(4), .GAP(1), .FILL(1'b0)) dut_a (
    .clock(clk), .reset(rst), .din(din), .din_dir(dir), .din_valid(vld_a),
    .din_ready(rdy_a), .usr_s1(s1_a), .usr_s0(s0_a), .usr_in(ui_a),
    .usr_msb_in(mi_a), .usr_lsb_in(li_a), .usr_msb_out(mo_a), .usr_lsb_out(lo_a),
    .ser_out(so_a), .ser_valid(sv_a), .ser_last(sl_a), .busy(busy_a)
  );

  usr_shift_ctrl #(.WIDTH(4), .GAP(0), .FILL(1'b0)) dut_b (
    .clock(clk), .reset(rst), .din(din), .din_dir(dir), .din_valid(vld_b),
    .din_ready(rdy_b), .usr_s1(s1_b), .usr_s0(s0_b), .usr_in(ui_b),
    .usr_msb_in(mi_b), .usr_lsb_in(li_b), .usr_msb_out(mo_b), .usr_lsb_out(lo_b),
    .ser_out(so_b), .ser_valid(sv_b), .ser_last(sl_b), .busy(busy_b)
  );

  // Behavioural universal shift registers driven by each controller.
  always @(posedge clk) begin
    case ({s1_a, s0_a})
      2'b01:   q_a <= {mi_a, q_a[3:1]};
      2'b10:   q_a <= {q_a[2:0], li_a};
      2'b11:   q_a <= ui_a;
      default: q_a <= q_a;
    endcase
    case ({s1_b, s0_b})
      2'b01:   q_b <= {mi_b, q_b[3:1]};
      2'b10:   q_b <= {q_b[2:0], li_b};
      2'b11:   q_b <= ui_b;
      default: q_b <= q_b;
    endcase
  end
  assign mo_a = q_a[3];
  assign lo_a = q_a[0];
  assign mo_b = q_b[3];
  assign lo_b = q_b[0];

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] qa[$];
  logic [1:0] qb[$];
  logic [1:0] ea, eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected serial bits {bit, last} for one word, in transmit order.
  task automatic push_word(input bit to_b, input logic [3:0] w, input logic d);
    logic bv;
    for (int i = 0; i < 4; i++) begin
      bv = d ? w[3 - i] : w[i];
      if (to_b) qb.push_back({bv, (i == 3)});
      else      qa.push_back({bv, (i == 3)});
    end
  endtask

  // Stream monitor: pops an expected bit whenever a DUT presents one.
  always @(negedge clk) begin
    if (sv_a === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL stream_a: unexpected bit %0b, nothing expected (t=%0t)", so_a, $time);
      end else begin
        ea = qa.pop_front();
        chk("stream_a {bit,last}", {30'd0, so_a, sl_a}, {30'd0, ea});
      end
    end
    if (sv_b === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL stream_b: unexpected bit %0b, nothing expected (t=%0t)", so_b, $time);
      end else begin
        eb = qb.pop_front();
        chk("stream_b {bit,last}", {30'd0, so_b, sl_b}, {30'd0, eb});
      end
    end
  end

  // One full word on instance A from an IDLE start, checking selects per cycle.
  task automatic word_a(input logic [3:0] w, input logic d, input string tag);
    @(posedge clk); #1; din = w; dir = d; vld_a = 1'b1; push_word(0, w, d);
    @(negedge clk); chk({tag, "_ready"}, rdy_a, 1);
    @(posedge clk); #1; vld_a = 1'b0;
    @(negedge clk);
    chk({tag, "_load_sel"}, {s1_a, s0_a}, 2'b11);
    chk({tag, "_load_usr_in"}, ui_a, w);
    chk({tag, "_load_ready"}, rdy_a, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, "_shift_sel"}, {s1_a, s0_a}, (i < 3) ? (d ? 2'b10 : 2'b01) : 2'b00);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_gap_busy"}, busy_a, 1);
    chk({tag, "_gap_ready"}, rdy_a, 0);
    chk({tag, "_gap_sel"}, {s1_a, s0_a}, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk({tag, "_idle_ready"}, rdy_a, 1);
    chk({tag, "_idle_busy"}, busy_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_ready_a", rdy_a, 0);
    chk("rst_ready_b", rdy_b, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_sel", {s1_a, s0_a}, 2'b00);
    chk("rst_usr_in", ui_a, 4'h0);
    chk("rst_ser", {so_a, sv_a, sl_a}, 3'b000);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready_a", rdy_a, 1);
    chk("post_rst_ready_b", rdy_b, 1);

    // LSB-first and MSB-first single words
    word_a(4'b1011, 1'b0, "lsb");
    word_a(4'b1011, 1'b1, "msb");

    // Reset mid-SHIFT: two bits go out, the rest is dropped
    @(posedge clk); #1; din = 4'b1011; dir = 1'b0; vld_a = 1'b1;
    qa.push_back(2'b10); qa.push_back(2'b10);
    @(posedge clk); #1; vld_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; vld_a = 1'b1; din = 4'hF;
    @(negedge clk);
    chk("midrst_valid", sv_a, 0);
    chk("midrst_last", sl_a, 0);
    chk("midrst_sel", {s1_a, s0_a}, 2'b00);
    chk("midrst_busy", busy_a, 0);
    chk("midrst_ready", rdy_a, 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_busy2", busy_a, 0);
    @(posedge clk); #1; rst = 1'b0; vld_a = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", rdy_a, 1);
    chk("rst_vs_valid_busy", busy_a, 0);
    chk("rst_vs_valid_hold", ui_a, 4'h0);

    // Back-to-back with valid held high: A then 5
    @(posedge clk); #1; din = 4'hA; dir = 1'b0; vld_a = 1'b1; push_word(0, 4'hA, 1'b0);
    @(negedge clk); chk("b2b_accept0", rdy_a, 1);
    for (int j = 1; j <= 6; j++) begin
      @(posedge clk); #1;
      if (j == 1) din = 4'h5;
      @(negedge clk); chk("b2b_not_ready", rdy_a, 0);
    end
    @(posedge clk); #1;
    @(negedge clk); chk("b2b_accept1", rdy_a, 1); push_word(0, 4'h5, 1'b0);
    @(posedge clk); #1; vld_a = 1'b0;
    @(negedge clk); chk("b2b_load_usr_in", ui_a, 4'h5);
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk); chk("b2b_end_ready", rdy_a, 1);

    // Ignored input during SHIFT of word 0
    @(posedge clk); #1; din = 4'h0; dir = 1'b0; vld_a = 1'b1; push_word(0, 4'h0, 1'b0);
    @(posedge clk); #1; vld_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; din = 4'hF; vld_a = 1'b1;
    @(posedge clk); #1; vld_a = 1'b0;
    @(negedge clk); chk("ign_hold", ui_a, 4'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("ign_hold2", ui_a, 4'h0); chk("ign_busy", busy_a, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("ign_gap_ready", rdy_a, 0);
    @(posedge clk); #1;
    @(negedge clk); chk("ign_idle_ready", rdy_a, 1); chk("ign_hold3", ui_a, 4'h0);
    @(posedge clk); #1;
    @(negedge clk); chk("ign_no_capture", busy_a, 0);

    // GAP=0 instance: continuous valid, MSB-first words 6, 9, C
    for (int k = 0; k <= 12; k++) begin
      @(posedge clk); #1;
      if (k == 0)  begin din = 4'h6; dir = 1'b1; vld_b = 1'b1; end
      if (k == 6)  din = 4'h9;
      if (k == 12) din = 4'hC;
      if (k % 6 == 0) push_word(1, din, 1'b1);
      @(negedge clk);
      chk("g0_ready", rdy_b, (k % 6 == 0) ? 1 : 0);
      chk("g0_last", sl_b, (k % 6 == 5) ? 1 : 0);
    end
    @(posedge clk); #1; vld_b = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("g0_end_ready", rdy_b, 1);
    chk("g0_end_busy", busy_b, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
